writeback_buffer: RTL

Buffers register writeback requests from the execute/memory stages and drains them, one per cycle and in order, into the single write port of the register file. It sits directly upstream of the register file write port. Optionally it provides a forwarding lookup so the decode stage can obtain values that are queued but not yet written.

---
 rtl/writeback_buffer.sv | 116 +++++++++++
 1 files changed

// File: rtl/writeback_buffer.sv
// writeback_buffer: in-order FIFO between the execute/memory stages and the
// single register file write port. Drains at most one entry per cycle into a
// registered write port.
// Optional feature macro: WRITEBACK_FORWARD_EN enables the decode-stage
// forwarding lookup. When undefined, lookup_hit/lookup_data are tied to 0.
module writeback_buffer #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32
) (
    input  logic                       CLK,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [4:0]                 in_index,
    input  logic [XLEN-1:0]            in_data,
    input  logic                       drain_hold,
    output logic                       write_enable,
    output logic [4:0]                 write_index,
    output logic [XLEN-1:0]            write_data,
    input  logic [4:0]                 lookup_index,
    output logic                       lookup_hit,
    output logic [XLEN-1:0]            lookup_data,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [4:0]      idx_mem  [DEPTH];
    logic [XLEN-1:0] data_mem [DEPTH];
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   wr_ptr;
    logic            push;
    logic            store;
    logic            pop;

    // Full blocks intake even if a pop happens on the same edge.
    assign in_ready = (count != CW'(DEPTH));
    assign push     = in_valid && in_ready;
    // Writes to x0 complete the handshake but are discarded.
    assign store    = push && (in_index != 5'd0);
    assign pop      = (count != '0) && !drain_hold;

    // Entry storage and write pointer.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                idx_mem[i]  <= '0;
                data_mem[i] <= '0;
            end
        end else if (store) begin
            idx_mem[wr_ptr]  <= in_index;
            data_mem[wr_ptr] <= in_data;
            wr_ptr           <= wr_ptr + 1'b1;
        end
    end

    // Read pointer, occupancy and the registered register-file write port.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            rd_ptr       <= '0;
            count        <= '0;
            write_enable <= 1'b0;
            write_index  <= '0;
            write_data   <= '0;
        end else begin
            if (pop) begin
                write_enable <= 1'b1;
                write_index  <= idx_mem[rd_ptr];
                write_data   <= data_mem[rd_ptr];
                rd_ptr       <= rd_ptr + 1'b1;
            end else begin
                write_enable <= 1'b0;
            end
            case ({store, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

`ifdef WRITEBACK_FORWARD_EN
    logic [AW-1:0] slot;

    // Forwarding search: output register first, then stored entries oldest to
    // youngest so that the youngest match overrides everything before it.
    always_comb begin
        lookup_hit  = 1'b0;
        lookup_data = '0;
        slot        = '0;
        if (lookup_index != 5'd0) begin
            if (write_enable && (write_index == lookup_index)) begin
                lookup_hit  = 1'b1;
                lookup_data = write_data;
            end
            for (int i = 0; i < DEPTH; i++) begin
                slot = rd_ptr + AW'(i);
                if ((CW'(i) < count) && (idx_mem[slot] == lookup_index)) begin
                    lookup_hit  = 1'b1;
                    lookup_data = data_mem[slot];
                end
            end
        end
    end
`else
    logic unused_lookup;

    // Forwarding absent: outputs constant, lookup_index deliberately ignored.
    assign lookup_hit    = 1'b0;
    assign lookup_data   = '0;
    assign unused_lookup = ^lookup_index;
`endif

endmodule
